// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive-side command path.
//   - ASCII constants used by the hex line parser
//   - parser FSM state encoding
//   - character classification result struct
package uart_pkg;

  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_9    = 8'h39;
  localparam logic [7:0] CHAR_A_LO = 8'h61;
  localparam logic [7:0] CHAR_F_LO = 8'h66;
  localparam logic [7:0] CHAR_A_UP = 8'h41;
  localparam logic [7:0] CHAR_F_UP = 8'h46;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HOLD    = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic       is_digit;
    logic       is_term;
    logic [3:0] nib;
  } char_class_t;

endpackage

// File: rtl/hex_char_classify.sv
// hex_char_classify: combinational ASCII byte classifier.
//   rx_data_i  in  8   ASCII byte
//   cls_o      out     {is_digit, is_term, nib}; nib valid only when is_digit
module hex_char_classify
  import uart_pkg::*;
(
  input  logic [7:0]  rx_data_i,
  output char_class_t cls_o
);

  always_comb begin
    cls_o = '0;
    if (rx_data_i >= CHAR_0 && rx_data_i <= CHAR_9) begin
      cls_o.is_digit = 1'b1;
      cls_o.nib      = rx_data_i[3:0];
    end else if ((rx_data_i >= CHAR_A_LO && rx_data_i <= CHAR_F_LO) ||
                 (rx_data_i >= CHAR_A_UP && rx_data_i <= CHAR_F_UP)) begin
      // 'a'/'A' have low nibble 1, so +9 maps a..f onto 10..15
      cls_o.is_digit = 1'b1;
      cls_o.nib      = rx_data_i[3:0] + 4'd9;
    end else if (rx_data_i == CHAR_CR || rx_data_i == CHAR_LF) begin
      cls_o.is_term  = 1'b1;
    end
  end

endmodule

// File: rtl/hex_line_parser.sv
// hex_line_parser: assembles ASCII hex lines into DATA_W-bit words.
//   clk, rst    clock / async active-high reset
//   rx_data     received byte, qualified by rx_valid (1-cycle strobe)
//   word_out    assembled word, right-aligned, zero-extended
//   word_valid  held until word_valid & word_ready
//   word_ready  consumer accept
//   err_char    pulse: non-hex, non-terminator byte
//   err_len     pulse: digit beyond DATA_W/4 digits
//   overrun     pulse: byte dropped while a word is pending
//   busy        parser not idle
module hex_line_parser
  import uart_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err_char,
  output logic              err_len,
  output logic              overrun,
  output logic              busy
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  if (DATA_W < 4 || (DATA_W % 4) != 0) begin : g_bad_width
    $error("hex_line_parser: DATA_W must be a multiple of 4, at least 4");
  end

  parse_state_e      state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              wvalid_q, wvalid_d;
  logic              err_char_q, err_char_d;
  logic              err_len_q, err_len_d;
  logic              overrun_q, overrun_d;

  char_class_t cls;
  logic        accept, idle_like, invalid;

  hex_char_classify u_classify (
    .rx_data_i (rx_data),
    .cls_o     (cls)
  );

  assign accept    = wvalid_q & word_ready;
  // an accepted HOLD frees the parser in the same cycle, so the byte is taken as in IDLE
  assign idle_like = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & accept);
  assign invalid   = ~cls.is_digit & ~cls.is_term;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (idle_like) begin
          state_d = ST_IDLE;
          if (rx_valid) begin
            if (cls.is_digit) state_d = ST_ACCUM;
            else if (invalid) state_d = ST_DISCARD;
          end
        end
      end
      ST_ACCUM: begin
        if (rx_valid) begin
          if (cls.is_digit) begin
            if (cnt_q == CNT_W'(NIBBLES)) state_d = ST_DISCARD;
          end else if (cls.is_term) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: if (rx_valid && cls.is_term) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // datapath / outputs next values
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wvalid_d   = wvalid_q & ~accept;
    err_char_d = 1'b0;
    err_len_d  = 1'b0;
    overrun_d  = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (!idle_like) begin
            overrun_d = 1'b1;
          end else if (cls.is_digit) begin
            acc_d = DATA_W'(cls.nib);
            cnt_d = CNT_W'(1);
          end else if (invalid) begin
            err_char_d = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (cls.is_digit) begin
            if (cnt_q == CNT_W'(NIBBLES)) begin
              err_len_d = 1'b1;
            end else begin
              acc_d = DATA_W'({acc_q, cls.nib});
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (cls.is_term) begin
            word_d   = acc_q;
            wvalid_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            err_char_d = 1'b1;
          end
        end
        ST_DISCARD: begin
          if (cls.is_term) begin
            acc_d = '0;
            cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      wvalid_q   <= 1'b0;
      err_char_q <= 1'b0;
      err_len_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wvalid_q   <= wvalid_d;
      err_char_q <= err_char_d;
      err_len_q  <= err_len_d;
      overrun_q  <= overrun_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = wvalid_q;
  assign err_char   = err_char_q;
  assign err_len    = err_len_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hex_line_parser.sv
// tb_hex_line_parser: scoreboard bench for hex_line_parser.
//   Expected words are queued when a line is driven and popped when the DUT
//   hands a word over (word_valid & word_ready, sampled on the falling edge).
module tb_hex_line_parser;
  import uart_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic              err_char, err_len, overrun, busy;

  hex_line_parser #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err_char   (err_char),
    .err_len    (err_len),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_err_char = 0, n_err_len = 0, n_overrun = 0, n_words = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // monitor: pulse counting and word scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (err_char) n_err_char++;
      if (err_len)  n_err_len++;
      if (overrun)  n_overrun++;
      if (word_valid && word_ready) begin
        n_words++;
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("word_out", word_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    // reset state
    #12;
    check("rst_word_valid", word_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_word_out", word_out, 0);
    check("rst_errs", {err_char, err_len, overrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // 1: "1f\r"
    word_ready = 1'b1;
    send_str("1f");
    check("t1_busy", busy, 1);
    exp_q.push_back(32'h0000001F);
    send(CHAR_CR);
    check("t1_valid_latency", word_valid, 1);
    check("t1_word_now", word_out, 32'h1F);
    drain("t1_drain");
    tick(2);
    check("t1_no_errs", n_err_char + n_err_len + n_overrun, 0);

    // 2: "DEADBEEF\r\n" -> single word
    w0 = n_words;
    exp_q.push_back(32'hDEADBEEF);
    send_str("DEADBEEF");
    send(CHAR_CR);
    send(CHAR_LF);
    tick(3);
    drain("t2_drain");
    check("t2_one_word", n_words - w0, 1);
    check("t2_idle", busy, 0);

    // 3: over-length line
    w0 = n_words;
    send_str("12345678");
    send("9");
    check("t3_err_len_pulse", err_len, 1);
    send(CHAR_LF);
    check("t3_err_len_gone", err_len, 0);
    check("t3_no_word", word_valid, 0);
    check("t3_idle", busy, 0);
    exp_q.push_back(32'h5);
    send("5");
    send(CHAR_LF);
    drain("t3_drain");
    check("t3_words", n_words - w0, 1);

    // 4: invalid char then discard
    send_str("12g");
    check("t4_err_char_pulse", err_char, 1);
    send("4");
    check("t4_no_pulse", err_char, 0);
    send(CHAR_CR);
    check("t4_idle", busy, 0);
    exp_q.push_back(32'h7);
    send("7");
    send(CHAR_LF);
    drain("t4_drain");

    // 5: overrun while holding, then accept with a new byte
    word_ready = 1'b0;
    exp_q.push_back(32'hA);
    send("A");
    send(CHAR_CR);
    check("t5_valid", word_valid, 1);
    send("B");
    check("t5_overrun_pulse", overrun, 1);
    check("t5_word_held", word_out, 32'hA);
    tick(2);
    check("t5_still_valid", word_valid, 1);
    check("t5_overrun_gone", overrun, 0);
    word_ready = 1'b1;
    send("3");
    check("t5_valid_dropped", word_valid, 0);
    check("t5_new_line", busy, 1);
    check("t5_queue_popped", exp_q.size(), 0);
    exp_q.push_back(32'h3);
    send(CHAR_CR);
    drain("t5_drain");

    // 6: reset mid-line
    send_str("12");
    rst = 1'b1;
    #2;
    check("t6_busy", busy, 0);
    check("t6_word_valid", word_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    exp_q.push_back(32'h9);
    send("9");
    send(CHAR_CR);
    drain("t6_drain");

    // 7: random lines, mixed case, back-to-back bytes
    for (int l = 0; l < 20; l++) begin
      int len;
      logic [31:0] val;
      len = $urandom_range(1, 8);
      val = '0;
      for (int k = 0; k < len; k++) begin
        int d;
        logic [7:0] c;
        d = $urandom_range(0, 15);
        val = {val[27:0], 4'(d)};
        if (d < 10)                  c = 8'(CHAR_0 + d);
        else if ($urandom_range(0,1)) c = 8'(CHAR_A_UP + d - 10);
        else                          c = 8'(CHAR_A_LO + d - 10);
        send(c);
      end
      exp_q.push_back(val);
      send($urandom_range(0, 1) ? CHAR_CR : CHAR_LF);
    end
    drain("t7_drain");

    check("tot_err_char", n_err_char, 1);
    check("tot_err_len", n_err_len, 1);
    check("tot_overrun", n_overrun, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
